iob_bus_merge: RTL and testbench
================================

IOB_BUS_MERGE -- requirements
Module: iob_bus_merge

Interface
REQ-001 Parameter ADDR_W, default 32, width of the native-bus address field.
REQ-002 Parameter DATA_W, default 32, width of the data fields; WSTRB_W = DATA_W/8.
REQ-003 Derived widths SHALL be REQ_W = 1+ADDR_W+DATA_W+WSTRB_W and RESP_W = DATA_W+2.
REQ-004 Request packing, MSB to LSB, SHALL be {avalid, addr, wdata, wstrb}; response packing, MSB to LSB, SHALL be {rdata, rvalid, ready}.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 m0_req  input  REQ_W  master 0 request (instruction bus, ibus_req).
REQ-008 m0_resp  output  RESP_W  master 0 response.
REQ-009 m1_req  input  REQ_W  master 1 request (data bus, dbus_req).
REQ-010 m1_resp  output  RESP_W  master 1 response.
REQ-011 s_req  output  REQ_W  merged request to the single memory port.
REQ-012 s_resp  input  RESP_W  memory port response.

Function
REQ-013 The block SHALL merge two native-bus masters onto one slave port, with at most one read outstanding at any time.
REQ-014 A transfer SHALL be accepted in a cycle where s_req.avalid=1 and s_resp.ready=1; a write (wstrb!=0) completes on acceptance; a read (wstrb==0) completes on the first later cycle with s_resp.rvalid=1.
REQ-015 FSM states SHALL be IDLE, LOCK and RDWAIT; rr pointer (1 bit) selects the priority master.
REQ-016 IDLE: if exactly one master has avalid=1, grant it; if both, grant the master indicated by rr; grant is combinational in that cycle.
REQ-017 IDLE, granted request accepted: write -> stay IDLE; read -> RDWAIT with owner = granted master; rr <= index of the non-granted master.
REQ-018 IDLE, granted request not accepted (s_resp.ready=0) -> LOCK with owner = granted master; the grant SHALL NOT change until acceptance, even if the other master asserts avalid.
REQ-019 LOCK: forward the owner's request; on acceptance go to IDLE (write) or RDWAIT (read) and update rr as in REQ-017; if owner drops avalid before acceptance, return to IDLE without update.
REQ-020 RDWAIT: s_req.avalid SHALL be 0; on s_resp.rvalid=1 route it to the owner and go to IDLE on the next edge; no new grant in the rvalid cycle (one-cycle bubble).
REQ-021 s_req SHALL equal the granted master's request when a grant exists, else all zeros.
REQ-022 Granted master's ready SHALL equal s_resp.ready; non-granted master's ready SHALL be 0; no master sees ready=1 in RDWAIT.
REQ-023 rvalid and rdata SHALL be forwarded only to the RDWAIT owner; the other master sees rvalid=0 and rdata=0.
REQ-024 s_resp.rvalid=1 in IDLE or LOCK SHALL be ignored (no state change, not forwarded).
REQ-025 Forward path SHALL add zero cycles of latency: request, ready, rvalid and rdata are combinational through the mux from registered owner/state.
REQ-026 No combinational path SHALL exist from s_resp.rvalid to s_req.avalid.

Reset
REQ-027 On rst=1 at a clock edge: state <= IDLE, owner <= m0, rr <= m0 (master 0 has priority first).
REQ-028 While state is IDLE after reset, all outputs SHALL be combinational functions of current inputs per REQ-016..023.
REQ-029 Reset during LOCK or RDWAIT SHALL abandon the transfer; a later s_resp.rvalid for it SHALL be ignored per REQ-024.

Verification
REQ-030 Single read m0 addr 0x100, ready=1, rvalid 2 cycles later with rdata 0xDEADBEEF -> m0 rvalid=1, rdata=0xDEADBEEF; m1 rvalid=0 throughout.
REQ-031 Both masters avalid in the same cycle after reset, both reads -> m0 served first, m1 granted in the cycle after m0's rvalid cycle; rr=m0 afterwards.
REQ-032 m1 write wstrb=0xF, s_resp.ready=0 for 3 cycles while m0 asserts avalid -> s_req holds m1's request for 4 cycles; m0 ready=0 until m1 is accepted.
REQ-033 Back-to-back m1 writes with ready=1 every cycle -> one acceptance per cycle; no bubble; state stays IDLE.
REQ-034 rst asserted in RDWAIT, then stray rvalid=1 with rdata 0x12345678 -> neither master sees rvalid; state IDLE.
REQ-035 Spurious s_resp.rvalid=1 in IDLE with no request -> no output rvalid, state unchanged.

Source files
------------

// File: rtl/iob_bus_merge.sv
// Two-master native-bus merge onto a single memory port with at most one read in flight.
// Round-robin priority between the instruction (m0) and data (m1) masters.
//
// state  | meaning
// IDLE   | no transfer held; grant computed from current avalid and rr
// LOCK   | granted request stalled by ready=0; grant pinned to owner
// RDWAIT | read accepted; waiting for rvalid to route back to owner
module iob_bus_merge #(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  localparam int WSTRB_W = DATA_W / 8,
  localparam int REQ_W   = 1 + ADDR_W + DATA_W + WSTRB_W,
  localparam int RESP_W  = DATA_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  m0_req,
  output logic [RESP_W-1:0] m0_resp,
  input  logic [REQ_W-1:0]  m1_req,
  output logic [RESP_W-1:0] m1_resp,
  output logic [REQ_W-1:0]  s_req,
  input  logic [RESP_W-1:0] s_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK   = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   rr, rr_nxt;

  logic              m0_avalid, m1_avalid;
  logic              s_ready, s_rvalid;
  logic [DATA_W-1:0] s_rdata;

  assign m0_avalid = m0_req[REQ_W-1];
  assign m1_avalid = m1_req[REQ_W-1];
  assign s_ready   = s_resp[0];
  assign s_rvalid  = s_resp[1];
  assign s_rdata   = s_resp[RESP_W-1:2];

  logic             gnt_vld;
  logic             gnt_idx;
  logic [REQ_W-1:0] gnt_req;
  logic             gnt_is_write;
  logic             accept;

  // Grant depends only on registered state and request avalid, never on rvalid.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = owner;
    case (state)
      IDLE: begin
        gnt_vld = m0_avalid | m1_avalid;
        if (m0_avalid && m1_avalid) begin
          gnt_idx = rr;
        end else begin
          gnt_idx = m1_avalid;
        end
      end
      LOCK: begin
        gnt_vld = owner ? m1_avalid : m0_avalid;
      end
      default: begin
        gnt_vld = 1'b0;
      end
    endcase
  end

  assign gnt_req      = gnt_idx ? m1_req : m0_req;
  assign gnt_is_write = |gnt_req[WSTRB_W-1:0];
  assign accept       = gnt_vld & s_ready;
  assign s_req        = gnt_vld ? gnt_req : '0;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr;
    case (state)
      IDLE, LOCK: begin
        if (accept) begin
          owner_nxt = gnt_idx;
          rr_nxt    = ~gnt_idx;
          state_nxt = gnt_is_write ? IDLE : RDWAIT;
        end else if (gnt_vld) begin
          owner_nxt = gnt_idx;
          state_nxt = LOCK;
        end else begin
          // covers the owner withdrawing avalid while locked
          state_nxt = IDLE;
        end
      end
      RDWAIT: begin
        if (s_rvalid) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      rr    <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      rr    <= rr_nxt;
    end
  end

  logic              in_rdwait;
  logic              m0_ready, m1_ready;
  logic              m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;

  // Read data is routed only to the owner of the outstanding read.
  always_comb begin
    in_rdwait = (state == RDWAIT);
    m0_ready  = gnt_vld & ~gnt_idx & s_ready;
    m1_ready  = gnt_vld &  gnt_idx & s_ready;
    m0_rvalid = in_rdwait & ~owner & s_rvalid;
    m1_rvalid = in_rdwait &  owner & s_rvalid;
    m0_rdata  = (in_rdwait && !owner) ? s_rdata : '0;
    m1_rdata  = (in_rdwait &&  owner) ? s_rdata : '0;
  end

  assign m0_resp = {m0_rdata, m0_rvalid, m0_ready};
  assign m1_resp = {m1_rdata, m1_rvalid, m1_ready};

endmodule

// File: tb/tb_iob_bus_merge.sv
// Self-checking bench for iob_bus_merge: directed scenarios plus randomized
// traffic against a transaction-level arbitration model.
module tb_iob_bus_merge;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int WSTRB_W = DATA_W / 8;
  localparam int REQ_W   = 1 + ADDR_W + DATA_W + WSTRB_W;
  localparam int RESP_W  = DATA_W + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [REQ_W-1:0]  m0_req, m1_req, s_req;
  logic [RESP_W-1:0] m0_resp, m1_resp, s_resp;

  int n_checks = 0;
  int n_pass   = 0;

  iob_bus_merge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_resp(m0_resp),
    .m1_req(m1_req), .m1_resp(m1_resp),
    .s_req(s_req), .s_resp(s_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [REQ_W-1:0] mk_req(input logic av, input logic [ADDR_W-1:0] a,
                                              input logic [DATA_W-1:0] d, input logic [WSTRB_W-1:0] s);
    return {av, a, d, s};
  endfunction

  function automatic logic [RESP_W-1:0] mk_resp(input logic [DATA_W-1:0] d, input logic rv, input logic rdy);
    return {d, rv, rdy};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic do_reset();
    rst = 1'b1; m0_req = '0; m1_req = '0; s_resp = '0;
    next();
    next();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [REQ_W-1:0] r1;
    do_reset();
    settle();
    n_checks++; if (s_req !== '0) $display("FAIL rst_sreq: got %h want 0", s_req); else n_pass++;
    n_checks++; if (m0_resp !== '0) $display("FAIL rst_m0: got %h want 0", m0_resp); else n_pass++;
    n_checks++; if (m1_resp !== '0) $display("FAIL rst_m1: got %h want 0", m1_resp); else n_pass++;
    next();
    r1 = mk_req(1'b1, 32'h44, $urandom, 4'h3);
    m1_req = r1; s_resp = mk_resp('0, 1'b0, 1'b1);
    settle();
    n_checks++; if (s_req !== r1) $display("FAIL rst_comb_sreq: got %h want %h", s_req, r1); else n_pass++;
    n_checks++; if (m1_resp !== mk_resp('0, 1'b0, 1'b1)) $display("FAIL rst_comb_m1: got %h want rdy", m1_resp); else n_pass++;
    next();
    m1_req = '0;
  endtask

  task automatic test_single_read();
    logic [REQ_W-1:0] r0, r1;
    do_reset();
    r0 = mk_req(1'b1, 32'h100, $urandom, 4'h0);
    m0_req = r0; s_resp = mk_resp('0, 1'b0, 1'b1);
    settle();
    n_checks++; if (s_req !== r0) $display("FAIL sr_sreq: got %h want %h", s_req, r0); else n_pass++;
    n_checks++; if (m0_resp !== mk_resp('0, 1'b0, 1'b1)) $display("FAIL sr_m0_rdy: got %h", m0_resp); else n_pass++;
    n_checks++; if (m1_resp !== '0) $display("FAIL sr_m1_a: got %h want 0", m1_resp); else n_pass++;
    next();
    m0_req = '0; s_resp = mk_resp('0, 1'b0, 1'b1);
    settle();
    n_checks++; if (s_req !== '0) $display("FAIL sr_wait_sreq: got %h want 0", s_req); else n_pass++;
    n_checks++; if (m0_resp !== '0) $display("FAIL sr_wait_m0: got %h want 0", m0_resp); else n_pass++;
    n_checks++; if (m1_resp !== '0) $display("FAIL sr_m1_b: got %h want 0", m1_resp); else n_pass++;
    next();
    r1 = mk_req(1'b1, 32'h200, 32'h55, 4'hF);
    m1_req = r1; s_resp = mk_resp(32'hDEADBEEF, 1'b1, 1'b1);
    settle();
    n_checks++; if (m0_resp !== mk_resp(32'hDEADBEEF, 1'b1, 1'b0)) $display("FAIL sr_rdata: got %h want deadbeef/rvalid", m0_resp); else n_pass++;
    n_checks++; if (m1_resp !== '0) $display("FAIL sr_m1_c: got %h want 0", m1_resp); else n_pass++;
    n_checks++; if (s_req !== '0) $display("FAIL sr_bubble: got %h want 0", s_req); else n_pass++;
    next();
    s_resp = mk_resp('0, 1'b0, 1'b1);
    settle();
    n_checks++; if (s_req !== r1) $display("FAIL sr_after: got %h want %h", s_req, r1); else n_pass++;
    n_checks++; if (m1_resp !== mk_resp('0, 1'b0, 1'b1)) $display("FAIL sr_after_m1: got %h", m1_resp); else n_pass++;
    next();
    m1_req = '0;
  endtask

  task automatic test_both_reads();
    logic [REQ_W-1:0] r0, r1, w0, w1;
    do_reset();
    r0 = mk_req(1'b1, 32'h10, $urandom, 4'h0);
    r1 = mk_req(1'b1, 32'h20, $urandom, 4'h0);
    m0_req = r0; m1_req = r1; s_resp = mk_resp('0, 1'b0, 1'b1);
    settle();
    n_checks++; if (s_req !== r0) $display("FAIL br_first: got %h want %h", s_req, r0); else n_pass++;
    n_checks++; if (m1_resp !== '0) $display("FAIL br_m1_wait: got %h want 0", m1_resp); else n_pass++;
    next();
    m0_req = '0; s_resp = mk_resp(32'hA5A50001, 1'b1, 1'b1);
    settle();
    n_checks++; if (m0_resp !== mk_resp(32'hA5A50001, 1'b1, 1'b0)) $display("FAIL br_m0_data: got %h", m0_resp); else n_pass++;
    n_checks++; if (s_req !== '0) $display("FAIL br_bubble: got %h want 0", s_req); else n_pass++;
    n_checks++; if (m1_resp !== '0) $display("FAIL br_m1_bubble: got %h want 0", m1_resp); else n_pass++;
    next();
    s_resp = mk_resp('0, 1'b0, 1'b1);
    settle();
    n_checks++; if (s_req !== r1) $display("FAIL br_second: got %h want %h", s_req, r1); else n_pass++;
    n_checks++; if (m1_resp !== mk_resp('0, 1'b0, 1'b1)) $display("FAIL br_m1_rdy: got %h", m1_resp); else n_pass++;
    next();
    m1_req = '0; s_resp = mk_resp(32'h0000000B, 1'b1, 1'b0);
    settle();
    n_checks++; if (m1_resp !== mk_resp(32'h0000000B, 1'b1, 1'b0)) $display("FAIL br_m1_data: got %h", m1_resp); else n_pass++;
    n_checks++; if (m0_resp !== '0) $display("FAIL br_m0_quiet: got %h want 0", m0_resp); else n_pass++;
    next();
    w0 = mk_req(1'b1, 32'h30, $urandom, 4'hF);
    w1 = mk_req(1'b1, 32'h40, $urandom, 4'hF);
    m0_req = w0; m1_req = w1; s_resp = mk_resp('0, 1'b0, 1'b1);
    settle();
    n_checks++; if (s_req !== w0) $display("FAIL br_rr_m0: got %h want %h", s_req, w0); else n_pass++;
    next();
    m0_req = '0; m1_req = '0;
  endtask

  task automatic test_lock_write();
    logic [REQ_W-1:0] r0, w1;
    do_reset();
    w1 = mk_req(1'b1, 32'h300, $urandom, 4'hF);
    r0 = mk_req(1'b1, 32'h400, $urandom, 4'h0);
    m1_req = w1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) m0_req = r0;
      s_resp = mk_resp('0, 1'b0, (i == 3));
      settle();
      n_checks++; if (s_req !== w1) $display("FAIL lk_sreq[%0d]: got %h want %h", i, s_req, w1); else n_pass++;
      n_checks++; if (m0_resp !== '0) $display("FAIL lk_m0[%0d]: got %h want 0", i, m0_resp); else n_pass++;
      n_checks++; if (m1_resp !== mk_resp('0, 1'b0, (i == 3))) $display("FAIL lk_m1[%0d]: got %h", i, m1_resp); else n_pass++;
      next();
    end
    m1_req = '0; m0_req = r0; s_resp = mk_resp('0, 1'b0, 1'b0);
    settle();
    n_checks++; if (s_req !== r0) $display("FAIL lk_m0_grant: got %h want %h", s_req, r0); else n_pass++;
    next();
    m0_req = '0; m1_req = w1; s_resp = mk_resp('0, 1'b0, 1'b1);
    settle();
    n_checks++; if (s_req !== '0) $display("FAIL lk_drop_sreq: got %h want 0", s_req); else n_pass++;
    n_checks++; if (m1_resp !== '0) $display("FAIL lk_drop_m1: got %h want 0", m1_resp); else n_pass++;
    next();
    settle();
    n_checks++; if (s_req !== w1) $display("FAIL lk_after_drop: got %h want %h", s_req, w1); else n_pass++;
    next();
    m1_req = '0;
  endtask

  task automatic test_back_to_back();
    logic [REQ_W-1:0]  w1;
    logic [ADDR_W-1:0] a;
    int accepts;
    do_reset();
    accepts = 0;
    for (int i = 0; i < 6; i++) begin
      a = 32'h1000 + 32'(4 * i);
      w1 = mk_req(1'b1, a, $urandom, 4'hF);
      m1_req = w1; s_resp = mk_resp('0, 1'b0, 1'b1);
      settle();
      n_checks++; if (s_req !== w1) $display("FAIL b2b_sreq[%0d]: got %h want %h", i, s_req, w1); else n_pass++;
      if (m1_resp === mk_resp('0, 1'b0, 1'b1)) accepts++;
      next();
    end
    n_checks++; if (accepts !== 6) $display("FAIL b2b_accepts: got %0d want 6", accepts); else n_pass++;
    m1_req = '0;
  endtask

  task automatic test_reset_rdwait();
    logic [REQ_W-1:0] r0, w1;
    do_reset();
    r0 = mk_req(1'b1, 32'h500, $urandom, 4'h0);
    m0_req = r0; s_resp = mk_resp('0, 1'b0, 1'b1);
    next();
    m0_req = '0; s_resp = '0; rst = 1'b1;
    next();
    rst = 1'b0; s_resp = mk_resp(32'h12345678, 1'b1, 1'b0);
    settle();
    n_checks++; if (m0_resp !== '0) $display("FAIL rw_m0: got %h want 0", m0_resp); else n_pass++;
    n_checks++; if (m1_resp !== '0) $display("FAIL rw_m1: got %h want 0", m1_resp); else n_pass++;
    next();
    w1 = mk_req(1'b1, 32'h600, $urandom, 4'h1);
    m1_req = w1; s_resp = mk_resp('0, 1'b0, 1'b1);
    settle();
    n_checks++; if (s_req !== w1) $display("FAIL rw_idle: got %h want %h", s_req, w1); else n_pass++;
    next();
    m1_req = '0;
  endtask

  task automatic test_spurious_rvalid();
    logic [REQ_W-1:0] r0, w1;
    do_reset();
    s_resp = mk_resp($urandom, 1'b1, 1'b1);
    settle();
    n_checks++; if (m0_resp !== '0) $display("FAIL sp_m0: got %h want 0", m0_resp); else n_pass++;
    n_checks++; if (m1_resp !== '0) $display("FAIL sp_m1: got %h want 0", m1_resp); else n_pass++;
    n_checks++; if (s_req !== '0) $display("FAIL sp_sreq: got %h want 0", s_req); else n_pass++;
    next();
    w1 = mk_req(1'b1, 32'h700, $urandom, 4'hC);
    m1_req = w1; s_resp = mk_resp('0, 1'b0, 1'b0);
    next();
    s_resp = mk_resp($urandom, 1'b1, 1'b0);
    settle();
    n_checks++; if (m1_resp !== '0) $display("FAIL sp_lock_m1: got %h want 0", m1_resp); else n_pass++;
    n_checks++; if (s_req !== w1) $display("FAIL sp_lock_sreq: got %h want %h", s_req, w1); else n_pass++;
    next();
    r0 = mk_req(1'b1, 32'h800, $urandom, 4'h0);
    m0_req = r0; s_resp = mk_resp('0, 1'b0, 1'b1);
    settle();
    n_checks++; if (s_req !== w1) $display("FAIL sp_lock_hold: got %h want %h", s_req, w1); else n_pass++;
    next();
    m0_req = '0; m1_req = '0; s_resp = '0;
  endtask

  // Model: wait_m = master owed read data, hold_m = master pinned by a stall, prio = preferred master.
  task automatic test_random();
    int hold_m, wait_m, prio, g;
    logic [REQ_W-1:0]  rq [2];
    logic [REQ_W-1:0]  exp_s;
    logic [RESP_W-1:0] exp_r [2];
    logic              rdy, rv, do_rst;
    logic [DATA_W-1:0] rd;
    do_reset();
    hold_m = -1; wait_m = -1; prio = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int m = 0; m < 2; m++)
        rq[m] = mk_req(($urandom_range(0, 2) != 0), $urandom, $urandom,
                       ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom));
      rdy    = ($urandom_range(0, 1) == 1);
      rv     = ($urandom_range(0, 3) == 0);
      rd     = $urandom;
      do_rst = ($urandom_range(0, 63) == 0);
      m0_req = rq[0]; m1_req = rq[1]; s_resp = mk_resp(rd, rv, rdy); rst = do_rst;
      g = -1;
      if (wait_m >= 0) g = -1;
      else if (hold_m >= 0) g = rq[hold_m][REQ_W-1] ? hold_m : -1;
      else if (rq[0][REQ_W-1] && rq[1][REQ_W-1]) g = prio;
      else if (rq[0][REQ_W-1]) g = 0;
      else if (rq[1][REQ_W-1]) g = 1;
      exp_s = (g >= 0) ? rq[g] : '0;
      for (int m = 0; m < 2; m++)
        exp_r[m] = mk_resp((wait_m == m) ? rd : '0, (wait_m == m) && rv, (g == m) && rdy);
      settle();
      n_checks++; if (s_req !== exp_s) $display("FAIL rnd_sreq c%0d: got %h want %h", c, s_req, exp_s); else n_pass++;
      n_checks++; if (m0_resp !== exp_r[0]) $display("FAIL rnd_m0 c%0d: got %h want %h", c, m0_resp, exp_r[0]); else n_pass++;
      n_checks++; if (m1_resp !== exp_r[1]) $display("FAIL rnd_m1 c%0d: got %h want %h", c, m1_resp, exp_r[1]); else n_pass++;
      @(posedge clk);
      if (do_rst) begin
        hold_m = -1; wait_m = -1; prio = 0;
      end else if (wait_m >= 0) begin
        if (rv) wait_m = -1;
      end else if (g >= 0) begin
        if (rdy) begin
          prio = 1 - g;
          hold_m = -1;
          if (rq[g][WSTRB_W-1:0] == '0) wait_m = g;
        end else begin
          hold_m = g;
        end
      end else begin
        hold_m = -1;
      end
      #1;
    end
    rst = 1'b0; m0_req = '0; m1_req = '0; s_resp = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; m0_req = '0; m1_req = '0; s_resp = '0;
    test_reset();
    test_single_read();
    test_both_reads();
    test_lock_write();
    test_back_to_back();
    test_reset_rdwait();
    test_spurious_rvalid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
